// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//
// IF-stage branch predictor built around a direct-mapped branch target
// buffer (BTB). Each entry holds a valid bit, a tag, a target address and a
// 2-bit saturating counter. Lookup for the current fetch PC is purely
// combinational. Training comes from the ID stage once the condition checker
// has resolved the branch, and a wrong prediction raises a mispredict and
// redirect for the hazard unit to flush IF/ID.
//
// Optional build macro: BP_STATS_EN adds the stat_branches / stat_mispredicts
// saturating event counters. Without it those ports do not exist.
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous, active-low reset
//   if_pc            IF-stage PC (word aligned)
//   pred_taken       predicted direction for if_pc
//   pred_target      next fetch PC (BTB target if taken, else if_pc+4)
//   freeze           ID-stage stall, blocks training and mispredict
//   upd_valid        ID stage holds a valid instruction
//   upd_is_branch    ID instruction is a branch or jump
//   upd_pc           PC of the ID instruction
//   upd_taken        resolved branch condition
//   upd_target       resolved branch/jump target
//   upd_pred_taken   prediction that travelled with the instruction
//   upd_pred_target  predicted target that travelled with the instruction
//   mispredict       flush IF/ID and load redirect_pc this cycle
//   redirect_pc      correct next PC for the ID instruction
//   stat_branches    (BP_STATS_EN) count of trained branch cycles
//   stat_mispredicts (BP_STATS_EN) count of mispredict cycles
// ---------------------------------------------------------------------------
module branch_predictor #(
    parameter int WORD_LEN   = 32,
    parameter int INDEX_BITS = 4,
    parameter int TAG_BITS   = WORD_LEN - INDEX_BITS - 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WORD_LEN-1:0] if_pc,
    output logic                pred_taken,
    output logic [WORD_LEN-1:0] pred_target,
    input  logic                freeze,
    input  logic                upd_valid,
    input  logic                upd_is_branch,
    input  logic [WORD_LEN-1:0] upd_pc,
    input  logic                upd_taken,
    input  logic [WORD_LEN-1:0] upd_target,
    input  logic                upd_pred_taken,
    input  logic [WORD_LEN-1:0] upd_pred_target,
    output logic                mispredict,
    output logic [WORD_LEN-1:0] redirect_pc
`ifdef BP_STATS_EN
    ,
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_mispredicts
`endif
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    logic                validTbl  [ENTRIES];
    logic [TAG_BITS-1:0] tagTbl    [ENTRIES];
    logic [WORD_LEN-1:0] targetTbl [ENTRIES];
    logic [1:0]          ctrTbl    [ENTRIES];

    logic [INDEX_BITS-1:0] lookupIdx;
    logic [TAG_BITS-1:0]   lookupTag;
    logic                  lookupHit;
    logic [INDEX_BITS-1:0] updIdx;
    logic [TAG_BITS-1:0]   updTag;
    logic                  updHit;
    logic                  act;

    assign lookupIdx = if_pc[INDEX_BITS+1:2];
    assign lookupTag = if_pc[WORD_LEN-1:INDEX_BITS+2];
    assign updIdx    = upd_pc[INDEX_BITS+1:2];
    assign updTag    = upd_pc[WORD_LEN-1:INDEX_BITS+2];

    // The table reads the registered contents, so a same-index write in this
    // cycle only becomes visible to lookups from the next cycle.
    assign lookupHit = validTbl[lookupIdx] && (tagTbl[lookupIdx] == lookupTag);
    assign updHit    = validTbl[updIdx] && (tagTbl[updIdx] == updTag);

    // Qualifying with rst keeps mispredict and training quiet while in reset.
    assign act = upd_valid && !freeze && rst;

    assign pred_taken  = rst && lookupHit && ctrTbl[lookupIdx][1];
    assign pred_target = pred_taken ? targetTbl[lookupIdx] : (if_pc + WORD_LEN'(4));

    assign redirect_pc = upd_taken ? upd_target : (upd_pc + WORD_LEN'(4));

    // A non-branch that was predicted taken means an aliased entry steered
    // fetch away from the sequential path, which also needs a redirect.
    always_comb begin
        mispredict = 1'b0;
        if (act) begin
            if (upd_is_branch) begin
                mispredict = (upd_taken != upd_pred_taken) ||
                             (upd_taken && (upd_target != upd_pred_target));
            end else begin
                mispredict = upd_pred_taken;
            end
        end
    end

    // Table training. Taken misses allocate weakly taken; not-taken misses
    // are not worth an entry. A non-branch that hits its own tag evicts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                validTbl[i]  <= 1'b0;
                tagTbl[i]    <= '0;
                targetTbl[i] <= '0;
                ctrTbl[i]    <= 2'b01;
            end
        end else if (act) begin
            if (upd_is_branch) begin
                if (updHit) begin
                    if (upd_taken) begin
                        targetTbl[updIdx] <= upd_target;
                        if (ctrTbl[updIdx] != 2'b11) begin
                            ctrTbl[updIdx] <= ctrTbl[updIdx] + 2'b01;
                        end
                    end else if (ctrTbl[updIdx] != 2'b00) begin
                        ctrTbl[updIdx] <= ctrTbl[updIdx] - 2'b01;
                    end
                end else if (upd_taken) begin
                    validTbl[updIdx]  <= 1'b1;
                    tagTbl[updIdx]    <= updTag;
                    targetTbl[updIdx] <= upd_target;
                    ctrTbl[updIdx]    <= 2'b10;
                end
            end else if (updHit) begin
                validTbl[updIdx] <= 1'b0;
            end
        end
    end

`ifdef BP_STATS_EN
    // Event counters stick at all-ones rather than wrapping back to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (act && upd_is_branch && (stat_branches != 32'hFFFF_FFFF)) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (mispredict && (stat_mispredicts != 32'hFFFF_FFFF)) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
//
// Directed bench for branch_predictor. Inputs change on the falling edge and
// outputs are sampled 1 time unit later, so every rising edge sits between a
// drive and the next one. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        freeze;
    logic        upd_valid;
    logic        upd_is_branch;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int errors = 0;
    int checks = 0;

    branch_predictor dut (
        .clk             (clk),
        .rst             (rst),
        .if_pc           (if_pc),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .freeze          (freeze),
        .upd_valid       (upd_valid),
        .upd_is_branch   (upd_is_branch),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
        .redirect_pc     (redirect_pc)
`ifdef BP_STATS_EN
        ,
        .stat_branches   (stat_branches),
        .stat_mispredicts(stat_mispredicts)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one ID-stage update vector.
    task automatic applyStimulus(input logic valid, input logic isBranch,
                                 input logic [31:0] pc, input logic taken,
                                 input logic [31:0] target, input logic predTaken,
                                 input logic [31:0] predTarget);
        upd_valid       = valid;
        upd_is_branch   = isBranch;
        upd_pc          = pc;
        upd_taken       = taken;
        upd_target      = target;
        upd_pred_taken  = predTaken;
        upd_pred_target = predTarget;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance to the next falling edge, crossing exactly one rising edge.
    task automatic nextCycle();
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        // Reset with an update that would otherwise mispredict.
        rst    = 1'b0;
        freeze = 1'b0;
        if_pc  = 32'h40;
        applyStimulus(1'b1, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
        #1;
        checkOutput("rst_pred_taken", {31'b0, pred_taken}, 32'd0);
        checkOutput("rst_pred_target", pred_target, 32'h44);
        checkOutput("rst_mispredict", {31'b0, mispredict}, 32'd0);
        nextCycle();
        nextCycle();
        rst = 1'b1;

        // Taken branch miss: allocate and redirect. Same-cycle lookup sees old table.
        #1;
        checkOutput("alloc_mispredict", {31'b0, mispredict}, 32'd1);
        checkOutput("alloc_redirect", redirect_pc, 32'h100);
        checkOutput("alloc_same_cycle_lookup", {31'b0, pred_taken}, 32'd0);
        nextCycle();
        idle();
        #1;
        checkOutput("alloc_pred_taken", {31'b0, pred_taken}, 32'd1);
        checkOutput("alloc_pred_target", pred_target, 32'h100);

        // ctr 2 -> 3 -> 3, correctly predicted.
        nextCycle();
        applyStimulus(1'b1, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
        #1;
        checkOutput("taken_ok_mispredict", {31'b0, mispredict}, 32'd0);
        nextCycle();
        nextCycle();
        // Not taken while predicted taken: ctr 3 -> 2.
        applyStimulus(1'b1, 1'b1, 32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
        #1;
        checkOutput("nt_mispredict", {31'b0, mispredict}, 32'd1);
        checkOutput("nt_redirect", redirect_pc, 32'h44);
        nextCycle();
        idle();
        #1;
        checkOutput("ctr2_pred_taken", {31'b0, pred_taken}, 32'd1);
        // ctr 2 -> 1
        nextCycle();
        applyStimulus(1'b1, 1'b1, 32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
        nextCycle();
        idle();
        #1;
        checkOutput("ctr1_pred_taken", {31'b0, pred_taken}, 32'd0);
        checkOutput("ctr1_pred_target", pred_target, 32'h44);
        // ctr 1 -> 0 -> 0 (saturate)
        nextCycle();
        applyStimulus(1'b1, 1'b1, 32'h40, 1'b0, 32'h100, 1'b0, 32'h44);
        #1;
        checkOutput("nt_ok_mispredict", {31'b0, mispredict}, 32'd0);
        nextCycle();
        nextCycle();
        // ctr 0 -> 1: still not taken only if the floor held at 0.
        applyStimulus(1'b1, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
        nextCycle();
        idle();
        #1;
        checkOutput("ctr_floor_pred_taken", {31'b0, pred_taken}, 32'd0);
        // ctr 1 -> 2 with a new target.
        nextCycle();
        applyStimulus(1'b1, 1'b1, 32'h40, 1'b1, 32'h200, 1'b0, 32'h44);
        nextCycle();
        idle();
        #1;
        checkOutput("retarget_pred_taken", {31'b0, pred_taken}, 32'd1);
        checkOutput("retarget_pred_target", pred_target, 32'h200);

        // Non-branch alias at 0x440 (same index, other tag).
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h440, 1'b0, 32'h0, 1'b1, 32'h200);
        #1;
        checkOutput("alias_mispredict", {31'b0, mispredict}, 32'd1);
        checkOutput("alias_redirect", redirect_pc, 32'h444);
        nextCycle();
        idle();
        #1;
        checkOutput("alias_retained", pred_target, 32'h200);
        if_pc = 32'h440;
        #1;
        checkOutput("alias_lookup_miss", {31'b0, pred_taken}, 32'd0);
        checkOutput("alias_lookup_target", pred_target, 32'h444);

        // Frozen update at 0x84 must be ignored.
        nextCycle();
        if_pc  = 32'h84;
        freeze = 1'b1;
        applyStimulus(1'b1, 1'b1, 32'h84, 1'b1, 32'h300, 1'b0, 32'h88);
        #1;
        checkOutput("freeze_mispredict", {31'b0, mispredict}, 32'd0);
        nextCycle();
        #1;
        checkOutput("freeze_no_write", {31'b0, pred_taken}, 32'd0);
        freeze = 1'b0;
        #1;
        checkOutput("unfreeze_mispredict", {31'b0, mispredict}, 32'd1);
        checkOutput("unfreeze_redirect", redirect_pc, 32'h300);
        nextCycle();
        idle();
        #1;
        checkOutput("unfreeze_pred_target", pred_target, 32'h300);

        // Right direction, wrong target.
        applyStimulus(1'b1, 1'b1, 32'h84, 1'b1, 32'h300, 1'b1, 32'h999);
        #1;
        checkOutput("wrong_target_mispredict", {31'b0, mispredict}, 32'd1);
        nextCycle();
        idle();

        // Wrap of if_pc+4.
        if_pc = 32'hFFFF_FFFC;
        #1;
        checkOutput("wrap_pred_target", pred_target, 32'h0);

        // Non-branch hitting its own tag evicts the entry.
        nextCycle();
        if_pc = 32'h40;
        applyStimulus(1'b1, 1'b0, 32'h40, 1'b0, 32'h0, 1'b1, 32'h200);
        #1;
        checkOutput("evict_mispredict", {31'b0, mispredict}, 32'd1);
        nextCycle();
        idle();
        #1;
        checkOutput("evict_pred_taken", {31'b0, pred_taken}, 32'd0);

        // Not-taken miss does not allocate (first make it a taken-hit test).
        nextCycle();
        applyStimulus(1'b1, 1'b1, 32'h40, 1'b0, 32'h100, 1'b0, 32'h44);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
        #1;
        checkOutput("noalloc_then_taken_lookup", {31'b0, pred_taken}, 32'd0);
        nextCycle();
        idle();
        #1;
        checkOutput("realloc_pred_taken", {31'b0, pred_taken}, 32'd1);

        // Asynchronous reset mid-cycle clears the table at once.
        if_pc = 32'h84;
        #1;
        checkOutput("pre_reset_hit", {31'b0, pred_taken}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("async_reset_pred_taken", {31'b0, pred_taken}, 32'd0);
        nextCycle();
        rst = 1'b1;
        #1;
        checkOutput("post_reset_invalid", {31'b0, pred_taken}, 32'd0);
        checkOutput("post_reset_target", pred_target, 32'h88);

`ifdef BP_STATS_EN
        checkOutput("stat_branches_reset", stat_branches, 32'd0);
        checkOutput("stat_mispredicts_reset", stat_mispredicts, 32'd0);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
        nextCycle();
        freeze = 1'b1;
        applyStimulus(1'b1, 1'b1, 32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
        nextCycle();
        freeze = 1'b0;
        nextCycle();
        applyStimulus(1'b1, 1'b1, 32'hC0, 1'b0, 32'h0, 1'b0, 32'hC4);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h80, 1'b0, 32'h0, 1'b0, 32'h84);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
        nextCycle();
        idle();
        #1;
        checkOutput("stat_branches", stat_branches, 32'd5);
        checkOutput("stat_mispredicts", stat_mispredicts, 32'd2);
        rst = 1'b0;
        #1;
        checkOutput("stat_branches_clear", stat_branches, 32'd0);
        checkOutput("stat_mispredicts_clear", stat_mispredicts, 32'd0);
        if_pc = 32'h40;
        #1;
        checkOutput("stat_reset_invalid", {31'b0, pred_taken}, 32'd0);
        nextCycle();
        rst = 1'b1;
`endif

        nextCycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- IF-stage branch predictor: the issuing end of the branch path, paired with the ID-stage condition checker.
- Predicts taken/not-taken and target for the current IF PC using a direct-mapped branch target buffer with 2-bit saturating counters.
- Trains from ID-stage resolution (brCond plus the branch command).
- On a wrong prediction, drives a mispredict/redirect that the hazard unit uses to flush IF/ID.

Parameters:
- WORD_LEN, 32, data/address width (matches `WORD_LEN).
- INDEX_BITS, 4, log2 of BTB entries (16 entries); index = pc[INDEX_BITS+1:2].
- TAG_BITS, WORD_LEN-INDEX_BITS-2, tag = pc[WORD_LEN-1:INDEX_BITS+2].

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_pc  in  WORD_LEN  IF-stage PC (word aligned).
- pred_taken  out  1  prediction for if_pc.
- pred_target  out  WORD_LEN  next fetch PC: BTB target if pred_taken, else if_pc+4.
- freeze  in  1  ID-stage stall; suppresses training and mispredict.
- upd_valid  in  1  ID stage holds a valid instruction this cycle.
- upd_is_branch  in  1  instruction is a branch or jump (branch command != none).
- upd_pc  in  WORD_LEN  PC of the ID-stage instruction.
- upd_taken  in  1  resolved brCond from the condition checker.
- upd_target  in  WORD_LEN  resolved branch/jump target.
- upd_pred_taken  in  1  pred_taken piped alongside the instruction.
- upd_pred_target  in  WORD_LEN  pred_target piped alongside the instruction.
- mispredict  out  1  flush IF/ID and load redirect_pc this cycle.
- redirect_pc  out  WORD_LEN  correct next PC: upd_taken ? upd_target : upd_pc+4.

Behaviour:
- Entry state: valid, tag, target[WORD_LEN], ctr[1:0].
- Reset (async, rst=0): all valid=0, all ctr=2'b01, all tag/target=0.
- Outputs while in reset: pred_taken=0, pred_target=if_pc+4, mispredict=0.
- Lookup is combinational, zero latency. hit = valid[idx] && tag match. pred_taken = hit && ctr[1].
- Define act = upd_valid && !freeze.
- mispredict is combinational and requires act:
  - Branch (upd_is_branch=1): mispredict when upd_taken != upd_pred_taken, or when upd_taken && upd_target != upd_pred_target.
  - Non-branch (upd_is_branch=0): mispredict = upd_pred_taken (aliased entry).
- Training happens on the rising edge when act=1:
  - Branch hit: ctr increments if upd_taken, decrements if not, saturating at 3 and 0. If upd_taken, target <= upd_target.
  - Branch miss, taken: allocate. valid=1, tag, target=upd_target, ctr=2'b10 (weakly taken).
  - Branch miss, not taken: no allocation.
  - Non-branch with tag hit: clear valid (alias eviction).
- A lookup and an update to the same index in the same cycle: the lookup returns the pre-update contents; the write is visible from the next cycle.
- freeze=1: no table write and mispredict=0, even if upd_valid=1. The pipeline re-presents the instruction once the stall ends.
- PC arithmetic (+4) wraps modulo 2^WORD_LEN.
- Reset asserted mid-operation clears the table immediately. There is no pending state to drain.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined: adds outputs stat_branches[31:0] and stat_mispredicts[31:0].
  - stat_branches counts cycles with act && upd_is_branch.
  - stat_mispredicts counts cycles with mispredict=1.
  - Both counters saturate at 32'hFFFFFFFF and reset to 0 on rst.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset, then if_pc=0x40 -> pred_taken=0, pred_target=0x44, mispredict=0.
- Taken branch at 0x40, target 0x100, pred 0/0x44 -> mispredict=1, redirect_pc=0x100. Next cycle, if_pc=0x40 -> pred_taken=1, pred_target=0x100 (ctr=2).
- Resolve 0x40 taken twice, then not-taken once (pred 1/0x100) -> mispredict=1, redirect_pc=0x44. ctr goes 2→3→3→2, so the next lookup still predicts taken. Two more not-taken resolutions leave ctr=0 and pred_taken=0.
- Non-branch at 0x440 (same index as 0x40, different tag) with upd_pred_taken=1 -> mispredict=1, redirect_pc=0x444. The entry for 0x40 is retained (tag mismatch, no eviction).
- freeze=1 with a taken-branch update that would mispredict -> mispredict=0, table unchanged. Deassert freeze -> update applied and mispredict=1.
- With BP_STATS_EN: 5 branch updates including 2 mispredicts -> stat_branches=5, stat_mispredicts=2. Assert rst mid-run -> both counters 0 and all entries invalid.
